// File: rtl/jtl_delay_array.sv
// Array of JTL pulse-delay channels behind an OFF/RAMP/ON bias sequencer.
// Optional per-channel minimum-separation check: define JTL_SEP_CHECK_EN.
module jtl_delay_array #(
  parameter int CHANNELS = 4,
  parameter int STAGES   = 8,
  parameter int RAMP_CYC = 4,
  parameter int MIN_SEP  = 3,
  localparam int DW      = $clog2(STAGES + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                bias_en,
  input  logic [DW-1:0]       dly_sel,
  input  logic [CHANNELS-1:0] in,
  input  logic                err_clr,
  output logic [CHANNELS-1:0] out,
  output logic                ready,
  output logic [CHANNELS-1:0] err,
  output logic [1:0]          state_o
);

  localparam int RCW = $clog2(RAMP_CYC + 1);
  localparam int TW  = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [DW-1:0]  STAGES_W   = DW'(STAGES);
  localparam logic [RCW-1:0] RAMP_LAST  = RCW'(RAMP_CYC - 1);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_RAMP = 2'd1,
    S_ON   = 2'd2
  } state_t;

  state_t              state_q;
  logic [RCW-1:0]      ramp_cnt_q;
  logic [DW-1:0]       d_q;
  logic [DW-1:0]       d_d;
  logic                ready_q;
  logic [STAGES-1:0]   sr_q [CHANNELS];
  logic [CHANNELS-1:0] out_q;
  logic [CHANNELS-1:0] acc;
  logic [TW-1:0]       tap;
  logic                on_active;

  // ready is a level status, not a handshake: pulses on in are only taken
  // while ready is high and bias_en is still sampled high on that edge.
  assign on_active = (state_q == S_ON) && bias_en;
  assign ready     = ready_q;
  assign out       = out_q;
  assign state_o   = state_q;

  always_comb begin
    d_d = dly_sel;
    if (dly_sel == '0) begin
      d_d = DW'(1);
    end else if (dly_sel > STAGES_W) begin
      d_d = STAGES_W;
    end
  end

  assign tap = TW'(d_q - DW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_OFF;
      ramp_cnt_q <= '0;
      d_q        <= DW'(1);
      ready_q    <= 1'b0;
    end else if (!bias_en) begin
      state_q    <= S_OFF;
      ramp_cnt_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      case (state_q)
        S_OFF: begin
          state_q    <= S_RAMP;
          ramp_cnt_q <= '0;
        end
        S_RAMP: begin
          if (ramp_cnt_q == RAMP_LAST) begin
            state_q <= S_ON;
            ready_q <= 1'b1;
            d_q     <= d_d;
          end else begin
            ramp_cnt_q <= ramp_cnt_q + RCW'(1);
          end
        end
        S_ON: begin
          state_q <= S_ON;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_OFF;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // A pulse accepted at edge k lands in sr[0] and reaches out at edge k+D.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        sr_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (on_active) begin
          if (STAGES > 1) begin
            sr_q[c] <= {sr_q[c][STAGES-2:0], acc[c]};
          end else begin
            sr_q[c] <= STAGES'(acc[c]);
          end
          out_q[c] <= sr_q[c][tap];
        end else begin
          sr_q[c]  <= '0;
          out_q[c] <= 1'b0;
        end
      end
    end
  end

`ifdef JTL_SEP_CHECK_EN
  localparam int SW = $clog2(MIN_SEP + 1);
  localparam logic [SW-1:0] MIN_SEP_W = SW'(MIN_SEP);

  logic [SW-1:0]       sep_cnt_q [CHANNELS];
  logic [CHANNELS-1:0] seen_q;
  logic [CHANNELS-1:0] err_q;
  logic [CHANNELS-1:0] rej;

  // seen_q clears outside ON so the first pulse of each ON period always passes.
  always_comb begin
    acc = '0;
    rej = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (on_active && in[c]) begin
        if (!seen_q[c] || (sep_cnt_q[c] >= MIN_SEP_W)) begin
          acc[c] = 1'b1;
        end else begin
          rej[c] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q <= '0;
      err_q  <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        sep_cnt_q[c] <= '0;
      end
    end else begin
      err_q <= (err_q & ~{CHANNELS{err_clr}}) | rej;
      for (int c = 0; c < CHANNELS; c++) begin
        if (!on_active) begin
          seen_q[c]    <= 1'b0;
          sep_cnt_q[c] <= '0;
        end else if (acc[c]) begin
          seen_q[c]    <= 1'b1;
          sep_cnt_q[c] <= SW'(1);
        end else if (sep_cnt_q[c] < MIN_SEP_W) begin
          sep_cnt_q[c] <= sep_cnt_q[c] + SW'(1);
        end
      end
    end
  end

  assign err = err_q;
`else
  logic unused_err_clr;

  assign acc            = on_active ? in : '0;
  assign err            = '0;
  assign unused_err_clr = err_clr;
`endif

endmodule
